// File: rtl/simon_seq_player.sv
// simon_seq_player
//   Sequence player and checker for the memory game. Each round it appends one
//   symbol from the random generator to an internal buffer. It then plays the
//   whole buffer back, with each symbol lit for SHOW_CYCLES clocks followed by
//   SHOW_CYCLES dark clocks. Finally it checks the player's presses against the
//   buffer.
//
//   Optional feature macro: SIMON_TIMEOUT_EN. When it is defined, a player who
//   makes no press for TIMEOUT_CYCLES clocks in WAIT_IN loses the game.
//
// Ports
//   clk, reset_n   : clock and asynchronous active-low reset
//   rand_num[1:0]  : random symbol, sampled only while appending
//   start          : one-cycle pulse, begins a new game from IDLE/WIN/LOSE
//   btn_valid      : one-cycle pulse, btn_code carries a debounced press
//   btn_code[1:0]  : pressed symbol
//   show_valid     : a symbol is being displayed
//   show_code[1:0] : displayed symbol, 0 when show_valid is low
//   await_input    : waiting for the player's presses
//   round_len      : current sequence length
//   win, lose      : held game result
//
// Handshake: btn_valid and start are plain one-cycle strobes with no ready
// back-pressure. The block acts on a strobe only in the states that consume it
// and drops it silently in every other state, so nothing is queued.
module simon_seq_player #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   rand_num,
  input  logic                         start,
  input  logic                         btn_valid,
  input  logic [1:0]                   btn_code,
  output logic                         show_valid,
  output logic [1:0]                   show_code,
  output logic                         await_input,
  output logic [$clog2(MAX_LEN+1)-1:0] round_len,
  output logic                         win,
  output logic                         lose
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW,
    S_GAP,
    S_WAIT_IN,
    S_WIN,
    S_LOSE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [1:0]      mem_q [MAX_LEN];
  logic [1:0]      mem_d [MAX_LEN];

  logic            last_sym;
  logic            hold_done;
  logic            to_expired;

  // idx points at the final buffered symbol.
  assign last_sym  = (LW'(idx_q) == (len_q - LW'(1)));
  assign hold_done = (hold_q == HOLD_LAST);

`ifdef SIMON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;

  // The counter runs only in WAIT_IN, so it reads zero on every entry. Any
  // press clears it.
  always_comb begin
    to_d = '0;
    if (state_q == S_WAIT_IN && !btn_valid) begin
      to_d = to_q + TW'(1);
    end
  end

  // Expiry is flagged during the TIMEOUT_CYCLES-th idle cycle in WAIT_IN.
  // A press in that same cycle is handled first in the next-state logic.
  assign to_expired = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_d = S_APPEND;
          len_d   = '0;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      S_APPEND: begin
        // len_q < MAX_LEN here, because a full buffer ends in WIN instead.
        mem_d[len_q[IW-1:0]] = rand_num;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        hold_d  = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (hold_done) begin
          hold_d  = '0;
          state_d = S_GAP;
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      S_GAP: begin
        if (hold_done) begin
          hold_d = '0;
          if (last_sym) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SHOW;
          end
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      S_WAIT_IN: begin
        if (btn_valid) begin
          if (btn_code == mem_q[idx_q]) begin
            if (!last_sym) begin
              idx_d = idx_q + IW'(1);
            end else if (len_q == LEN_MAX) begin
              state_d = S_WIN;
            end else begin
              state_d = S_APPEND;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (to_expired) begin
          state_d = S_LOSE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Buffer contents are meaningless after reset, so they carry no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Moore outputs decoded from the registered state.
  assign show_valid  = (state_q == S_SHOW);
  assign show_code   = show_valid ? mem_q[idx_q] : 2'b00;
  assign await_input = (state_q == S_WAIT_IN);
  assign round_len   = len_q;
  assign win         = (state_q == S_WIN);
  assign lose        = (state_q == S_LOSE);

endmodule

// File: tb/tb_simon_seq_player.sv
module tb_simon_seq_player;

  localparam int MAX_LEN        = 4;
  localparam int SHOW_CYCLES    = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int LW             = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    rand_num;
  logic          start;
  logic          btn_valid;
  logic [1:0]    btn_code;
  logic          show_valid;
  logic [1:0]    show_code;
  logic          await_input;
  logic [LW-1:0] round_len;
  logic          win;
  logic          lose;

  int errors = 0;
  int checks = 0;

  // Reference model: the symbol sequence the player must see and repeat.
  logic [1:0] exp_q[$];

  simon_seq_player #(
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (SHOW_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rand_num    (rand_num),
    .start       (start),
    .btn_valid   (btn_valid),
    .btn_code    (btn_code),
    .show_valid  (show_valid),
    .show_code   (show_code),
    .await_input (await_input),
    .round_len   (round_len),
    .win         (win),
    .lose        (lose)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  // After step() the outputs reflect the state of the cycle just entered.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_code  = 2'd0;
    reset_n   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // ---------------- driver tasks ----------------
  // Begin a game: after this call the block sits in APPEND with sym pending.
  task automatic start_game(input logic [1:0] sym);
    rand_num = sym;
    start    = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (show_valid !== 1'b0 || await_input !== 1'b0 || win !== 1'b0 || lose !== 1'b0)
      begin
        errors++;
        $display("FAIL append_entry: show=%b await=%b win=%b lose=%b, required all 0",
                 show_valid, await_input, win, lose);
      end
    exp_q.delete();
    exp_q.push_back(sym);
  endtask

  // From APPEND: each symbol is lit SHOW_CYCLES clocks, then dark SHOW_CYCLES
  // clocks, after which the block waits for input. Stray presses, start pulses
  // and rand_num changes are injected throughout and must have no effect.
  task automatic playback();
    logic       want_v;
    logic [1:0] want_c;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int c = 0; c < 2 * SHOW_CYCLES; c++) begin
        step();
        want_v = (c < SHOW_CYCLES);
        want_c = want_v ? exp_q[i] : 2'd0;
        checks++;
        if (show_valid !== want_v || show_code !== want_c || await_input !== 1'b0 ||
            round_len !== LW'(exp_q.size())) begin
          errors++;
          $display("FAIL playback sym%0d cyc%0d: valid=%b code=%0d await=%b len=%0d, required %b/%0d/0/%0d",
                   i, c, show_valid, show_code, await_input, round_len,
                   want_v, want_c, exp_q.size());
        end
        btn_valid = 1'($urandom_range(0, 1));
        btn_code  = 2'($urandom_range(0, 3));
        start     = ($urandom_range(0, 7) == 0);
        rand_num  = 2'($urandom_range(0, 3));
      end
    end
    btn_valid = 1'b0;
    start     = 1'b0;
    step();
    checks++;
    if (await_input !== 1'b1 || show_valid !== 1'b0 || round_len !== LW'(exp_q.size()) ||
        win !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry: await=%b show=%b len=%0d win=%b lose=%b, required 1/0/%0d/0/0",
               await_input, show_valid, round_len, win, lose, exp_q.size());
    end
  endtask

  // Press the whole sequence. wrong_at selects a press to corrupt (-1 = none).
  // next_sym is offered on rand_num for the following APPEND.
  task automatic press_round(input int wrong_at, input logic [1:0] next_sym,
                             output bit game_over);
    int         n;
    logic [1:0] code;
    n         = exp_q.size();
    game_over = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        step();
        checks++;
        if (await_input !== 1'b1 || show_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_wait: await=%b show=%b, required 1/0", await_input, show_valid);
        end
      end
      code = exp_q[k];
      if (k == wrong_at) code = code + 2'(1 + $urandom_range(0, 2));
      btn_valid = 1'b1;
      btn_code  = code;
      rand_num  = next_sym;
      step();
      btn_valid = 1'b0;
      checks++;
      if (k == wrong_at) begin
        if (lose !== 1'b1 || win !== 1'b0 || await_input !== 1'b0) begin
          errors++;
          $display("FAIL wrong_press k%0d: lose=%b win=%b await=%b, required 1/0/0",
                   k, lose, win, await_input);
        end
        game_over = 1'b1;
        return;
      end else if (k < n - 1) begin
        if (await_input !== 1'b1 || lose !== 1'b0 || win !== 1'b0) begin
          errors++;
          $display("FAIL mid_press k%0d: await=%b lose=%b win=%b, required 1/0/0",
                   k, await_input, lose, win);
        end
      end else if (n == MAX_LEN) begin
        if (win !== 1'b1 || lose !== 1'b0 || await_input !== 1'b0) begin
          errors++;
          $display("FAIL final_win: win=%b lose=%b await=%b, required 1/0/0",
                   win, lose, await_input);
        end
        game_over = 1'b1;
      end else begin
        if (await_input !== 1'b0 || show_valid !== 1'b0 || win !== 1'b0 || lose !== 1'b0) begin
          errors++;
          $display("FAIL final_append: await=%b show=%b win=%b lose=%b, required all 0",
                   await_input, show_valid, win, lose);
        end
      end
    end
  endtask

  // Result must hold while stray presses arrive.
  task automatic hold_result(input bit want_win, input int want_len);
    repeat (4) begin
      btn_valid = 1'($urandom_range(0, 1));
      btn_code  = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (win !== want_win || lose !== !want_win || await_input !== 1'b0 ||
          show_valid !== 1'b0 || round_len !== LW'(want_len)) begin
        errors++;
        $display("FAIL hold_result: win=%b lose=%b await=%b show=%b len=%0d, required %b/%b/0/0/%0d",
                 win, lose, await_input, show_valid, round_len, want_win, !want_win, want_len);
      end
    end
    btn_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_code  = 2'd0;
    rand_num  = 2'd0;
    step();
    step();
    checks++;
    if (show_valid !== 1'b0) begin errors++; $display("FAIL reset_show_valid: got %b, required 0", show_valid); end
    checks++;
    if (show_code !== 2'd0) begin errors++; $display("FAIL reset_show_code: got %0d, required 0", show_code); end
    checks++;
    if (await_input !== 1'b0) begin errors++; $display("FAIL reset_await: got %b, required 0", await_input); end
    checks++;
    if (round_len !== '0) begin errors++; $display("FAIL reset_round_len: got %0d, required 0", round_len); end
    checks++;
    if (win !== 1'b0 || lose !== 1'b0) begin
      errors++; $display("FAIL reset_result: win=%b lose=%b, required 0/0", win, lose);
    end
    reset_n   = 1'b1;
    btn_valid = 1'b1;
    btn_code  = 2'd1;
    step();
    btn_valid = 1'b0;
    step();
    checks++;
    if (await_input !== 1'b0 || show_valid !== 1'b0 || round_len !== '0) begin
      errors++;
      $display("FAIL idle_ignores_press: await=%b show=%b len=%0d, required 0/0/0",
               await_input, show_valid, round_len);
    end
  endtask

  task automatic test_single_round();
    do_reset();
    start_game(2'd2);
    playback();
  endtask

  task automatic test_three_rounds();
    bit over;
    do_reset();
    start_game(2'd1);
    playback();
    press_round(-1, 2'd3, over);
    exp_q.push_back(2'd3);
    playback();
    press_round(-1, 2'd0, over);
    exp_q.push_back(2'd0);
    playback();
  endtask

  task automatic test_lose();
    bit over;
    do_reset();
    start_game(2'd1);
    playback();
    press_round(-1, 2'd3, over);
    exp_q.push_back(2'd3);
    playback();
    btn_valid = 1'b1;
    btn_code  = 2'd1;
    step();
    btn_valid = 1'b0;
    checks++;
    if (await_input !== 1'b1 || lose !== 1'b0) begin
      errors++;
      $display("FAIL lose_first_press: await=%b lose=%b, required 1/0", await_input, lose);
    end
    btn_valid = 1'b1;
    btn_code  = 2'd2;
    step();
    btn_valid = 1'b0;
    checks++;
    if (lose !== 1'b1 || await_input !== 1'b0) begin
      errors++;
      $display("FAIL lose_second_press: lose=%b await=%b, required 1/0", lose, await_input);
    end
    hold_result(1'b0, 2);
    start_game(2'd0);
    playback();
  endtask

  task automatic test_win();
    bit         over;
    logic [1:0] nxt;
    do_reset();
    start_game(2'($urandom_range(0, 3)));
    playback();
    for (int r = 0; r < MAX_LEN; r++) begin
      nxt = 2'($urandom_range(0, 3));
      press_round(-1, nxt, over);
      if (over) break;
      exp_q.push_back(nxt);
      playback();
    end
    checks++;
    if (win !== 1'b1 || round_len !== LW'(MAX_LEN)) begin
      errors++;
      $display("FAIL win_reached: win=%b len=%0d, required 1/%0d", win, round_len, MAX_LEN);
    end
    hold_result(1'b1, MAX_LEN);
    start_game(2'd3);
    playback();
  endtask

  task automatic test_reset_mid_show();
    bit over;
    do_reset();
    start_game(2'd0);
    playback();
    press_round(-1, 2'd2, over);
    exp_q.push_back(2'd2);
    playback();
    press_round(-1, 2'd1, over);
    step();
    step();
    checks++;
    if (show_valid !== 1'b1 || show_code !== 2'd0) begin
      errors++;
      $display("FAIL pre_reset_show: valid=%b code=%0d, required 1/0", show_valid, show_code);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (show_valid !== 1'b0 || show_code !== 2'd0 || await_input !== 1'b0 ||
        round_len !== '0 || win !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: show=%b code=%0d await=%b len=%0d win=%b lose=%b, required all 0",
               show_valid, show_code, await_input, round_len, win, lose);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (show_valid !== 1'b0 || round_len !== '0) begin
      errors++;
      $display("FAIL after_reset_idle: show=%b len=%0d, required 0/0", show_valid, round_len);
    end
    start_game(2'd3);
    playback();
  endtask

  task automatic test_random_games();
    bit         over;
    int         wrong;
    logic [1:0] nxt;
    do_reset();
    for (int g = 0; g < 6; g++) begin
      start_game(2'($urandom_range(0, 3)));
      playback();
      wrong = -1;
      for (int r = 0; r < MAX_LEN; r++) begin
        wrong = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
        nxt   = 2'($urandom_range(0, 3));
        press_round(wrong, nxt, over);
        if (over) break;
        exp_q.push_back(nxt);
        playback();
      end
      hold_result(wrong < 0, exp_q.size());
    end
  endtask

`ifdef SIMON_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_game(2'd2);
    playback();
    repeat (TIMEOUT_CYCLES - 1) step();
    checks++;
    if (await_input !== 1'b1 || lose !== 1'b0) begin
      errors++;
      $display("FAIL timeout_last_wait: await=%b lose=%b, required 1/0", await_input, lose);
    end
    step();
    checks++;
    if (lose !== 1'b1 || await_input !== 1'b0) begin
      errors++;
      $display("FAIL timeout_lose: lose=%b await=%b, required 1/0", lose, await_input);
    end
    start_game(2'd3);
    playback();
    repeat (TIMEOUT_CYCLES - 1) step();
    btn_valid = 1'b1;
    btn_code  = 2'd3;
    rand_num  = 2'd1;
    step();
    btn_valid = 1'b0;
    checks++;
    if (lose !== 1'b0 || await_input !== 1'b0 || win !== 1'b0) begin
      errors++;
      $display("FAIL timeout_press_wins: lose=%b await=%b win=%b, required 0/0/0",
               lose, await_input, win);
    end
    exp_q.push_back(2'd1);
    playback();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_round();
    test_three_rounds();
    test_lose();
    test_win();
    test_reset_mid_show();
    test_random_games();
`ifdef SIMON_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
